plic_gateway: RTL and testbench



---
 rtl/plic_gateway.sv | 138 +++++++++++++
 tb/tb_plic_gateway.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway in front of the PLIC priority/threshold core.
// Each raw IRQ line is synchronised, turned into one pending request
// (level or rising-edge), and held off while the core has it in service.
// The claim/complete handshake gates re-assertion, so each source has at
// most one outstanding request. Source 0 is reserved and never requests.
module plic_gateway #(
  parameter int unsigned IRQ_NUM     = 21,
  parameter int unsigned ID_WIDTH    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [IRQ_NUM-1:0]  irq_i,
  input  logic [IRQ_NUM-1:0]  edge_sel_i,
  input  logic                claim_i,
  input  logic [ID_WIDTH-1:0] claim_id_i,
  input  logic                complete_i,
  input  logic [ID_WIDTH-1:0] complete_id_i,
  output logic [IRQ_NUM-1:0]  ip_o,
  output logic [IRQ_NUM-1:0]  busy_o
);

  // State encoding doubles as the output encoding: bit 1 = ip, bit 0 = busy.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StInServ = 2'b01,
    StPend   = 2'b10
  } src_state_e;

  logic [IRQ_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_NUM-1:0] sync_s;
  logic [IRQ_NUM-1:0] hist_q;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] edge_rise;
  logic [IRQ_NUM-1:0] req;
  logic [IRQ_NUM-1:0] claim_hit;
  logic [IRQ_NUM-1:0] complete_hit;
  logic [IRQ_NUM-1:0] missed_q;
  src_state_e         state_q [IRQ_NUM];

  // Multi-flop synchroniser for every raw line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= irq_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // One cycle of history on the synchronised level for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= sync_s;
    end
  end

  assign rise      = sync_s & ~hist_q;
  assign edge_rise = edge_sel_i & rise;
  assign req       = edge_rise | (~edge_sel_i & sync_s);

  // Decode claim/complete IDs; ID 0 and out-of-range IDs match no source.
  always_comb begin
    claim_hit    = '0;
    complete_hit = '0;
    for (int i = 0; i < int'(IRQ_NUM); i++) begin
      claim_hit[i]    = claim_i && (i != 0) && (claim_id_i == ID_WIDTH'(i));
      complete_hit[i] = complete_i && (i != 0) && (complete_id_i == ID_WIDTH'(i));
    end
  end

  // Per-source request FSM plus the one-deep missed-edge flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(IRQ_NUM); i++) begin
        state_q[i] <= StIdle;
      end
      missed_q <= '0;
    end else begin
      for (int i = 0; i < int'(IRQ_NUM); i++) begin
        if (i == 0) begin
          state_q[i]  <= StIdle;
          missed_q[i] <= 1'b0;
        end else begin
          case (state_q[i])
            StIdle: begin
              if (req[i]) begin
                state_q[i] <= StPend;
              end
            end
            StPend: begin
              // A level that drops while pending is not retracted.
              if (claim_hit[i]) begin
                state_q[i] <= StInServ;
              end
              if (edge_rise[i]) begin
                missed_q[i] <= 1'b1;
              end
            end
            StInServ: begin
              if (complete_hit[i]) begin
                // A saved edge or an edge arriving right now re-pends the
                // source; a saved edge is consumed, a fresh one is kept.
                state_q[i]  <= (missed_q[i] || edge_rise[i]) ? StPend : StIdle;
                missed_q[i] <= missed_q[i] & edge_rise[i];
              end else if (edge_rise[i]) begin
                missed_q[i] <= 1'b1;
              end
            end
            default: begin
              state_q[i]  <= StIdle;
              missed_q[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Outputs are straight flop bits of the state encoding.
  always_comb begin
    ip_o   = '0;
    busy_o = '0;
    for (int i = 0; i < int'(IRQ_NUM); i++) begin
      ip_o[i]   = state_q[i][1];
      busy_o[i] = state_q[i][0];
    end
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: a behavioural model pushes the
// expected ip/busy vectors into a scoreboard queue before each clock edge;
// they are popped and compared just after the edge. Directed checks with
// constant expectations pin the test-plan scenarios.
module tb_plic_gateway;

  localparam int N  = 21;
  localparam int IW = 5;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  irq;
  logic [N-1:0]  edge_sel;
  logic          claim;
  logic [IW-1:0] claim_id;
  logic          complete;
  logic [IW-1:0] complete_id;
  logic [N-1:0]  ip;
  logic [N-1:0]  busy;

  plic_gateway #(
    .IRQ_NUM    (N),
    .ID_WIDTH   (IW),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .irq_i        (irq),
    .edge_sel_i   (edge_sel),
    .claim_i      (claim),
    .claim_id_i   (claim_id),
    .complete_i   (complete),
    .complete_id_i(complete_id),
    .ip_o         (ip),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ip;
    logic [N-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: 0 = idle, 1 = pending, 2 = in service.
  logic [N-1:0] m_sync0, m_sync1, m_hist;
  int           m_st[N];
  bit           m_miss[N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic void model_reset();
    m_sync0 = '0;
    m_sync1 = '0;
    m_hist  = '0;
    for (int i = 0; i < N; i++) begin
      m_st[i]   = 0;
      m_miss[i] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    logic [N-1:0] s;
    logic [N-1:0] r;
    s = m_sync1;
    r = s & ~m_hist;
    for (int i = 1; i < N; i++) begin
      bit er, rq, clm, cmp;
      er  = edge_sel[i] && r[i];
      rq  = edge_sel[i] ? r[i] : s[i];
      clm = claim && (int'(claim_id) == i);
      cmp = complete && (int'(complete_id) == i);
      case (m_st[i])
        0: if (rq) m_st[i] = 1;
        1: begin
          if (er) m_miss[i] = 1'b1;
          if (clm) m_st[i] = 2;
        end
        default: begin
          if (cmp) begin
            m_st[i]   = (m_miss[i] || er) ? 1 : 0;
            m_miss[i] = m_miss[i] && er;
          end else if (er) begin
            m_miss[i] = 1'b1;
          end
        end
      endcase
    end
    m_hist  = s;
    m_sync1 = m_sync0;
    m_sync0 = irq;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.ip   = '0;
    e.busy = '0;
    for (int i = 1; i < N; i++) begin
      e.ip[i]   = (m_st[i] == 1);
      e.busy[i] = (m_st[i] == 2);
    end
    return e;
  endfunction

  // One clock: predict, push, clock, pop, compare.
  task automatic tick();
    exp_t e;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq($sformatf("ip@%0d", cyc), 32'(ip), 32'(e.ip));
      check_eq($sformatf("busy@%0d", cyc), 32'(busy), 32'(e.busy));
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_claim(input int id);
    claim    = 1'b1;
    claim_id = IW'(id);
    tick();
    claim    = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete    = 1'b1;
    complete_id = IW'(id);
    tick();
    complete    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    irq         = '0;
    edge_sel    = '0;
    claim       = 1'b0;
    claim_id    = '0;
    complete    = 1'b0;
    complete_id = '0;
    model_reset();
    #12;
    check_eq("reset_ip", 32'(ip), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Level source 3: three-edge latency, claim, complete with line high.
    irq[3] = 1'b1;
    ticks(2);
    check_eq("lvl3_not_yet", 32'(ip[3]), 32'd0);
    tick();
    check_eq("lvl3_pend", 32'(ip[3]), 32'd1);
    do_claim(3);
    check_eq("lvl3_claim_ip", 32'(ip[3]), 32'd0);
    check_eq("lvl3_claim_busy", 32'(busy[3]), 32'd1);
    do_complete(3);
    check_eq("lvl3_idle_ip", 32'(ip[3]), 32'd0);
    check_eq("lvl3_idle_busy", 32'(busy[3]), 32'd0);
    tick();
    check_eq("lvl3_rearm", 32'(ip[3]), 32'd1);
    irq[3] = 1'b0;
    ticks(3);
    do_claim(3);
    do_complete(3);
    check_eq("lvl3_done", 32'(ip[3] | busy[3]), 32'd0);

    // Edge source 7: single pulse, missed edges during service.
    edge_sel[7] = 1'b1;
    irq[7] = 1'b1;
    tick();
    irq[7] = 1'b0;
    ticks(2);
    check_eq("edge7_pend", 32'(ip[7]), 32'd1);
    ticks(3);
    check_eq("edge7_hold", 32'(ip[7]), 32'd1);
    do_claim(7);
    check_eq("edge7_busy", 32'(busy[7]), 32'd1);
    for (int p = 0; p < 2; p++) begin
      irq[7] = 1'b1;
      tick();
      irq[7] = 1'b0;
      tick();
    end
    ticks(3);
    do_complete(7);
    check_eq("edge7_missed_repend", 32'(ip[7]), 32'd1);
    check_eq("edge7_missed_busy", 32'(busy[7]), 32'd0);
    do_claim(7);
    do_complete(7);
    check_eq("edge7_idle", 32'(ip[7] | busy[7]), 32'd0);
    ticks(2);
    check_eq("edge7_stays_idle", 32'(ip[7]), 32'd0);

    // Invalid IDs and reserved source 0.
    irq[3] = 1'b1;
    ticks(3);
    do_claim(0);
    do_claim(21);
    do_claim(31);
    do_complete(3);
    check_eq("inv_ip3", 32'(ip[3]), 32'd1);
    check_eq("inv_busy", 32'(busy), 32'd0);
    irq[0] = 1'b1;
    ticks(4);
    check_eq("src0_ip", 32'(ip[0]), 32'd0);
    irq[0] = 1'b0;
    irq[3] = 1'b0;
    do_claim(3);
    ticks(3);
    do_complete(3);

    // Concurrency: claim 1 and complete 5 in the same cycle.
    irq[5] = 1'b1;
    ticks(3);
    do_claim(5);
    irq[5] = 1'b0;
    irq[1] = 1'b1;
    irq[20] = 1'b1;
    ticks(3);
    claim       = 1'b1;
    claim_id    = IW'(1);
    complete    = 1'b1;
    complete_id = IW'(5);
    tick();
    claim    = 1'b0;
    complete = 1'b0;
    check_eq("cc_ip1", 32'(ip[1]), 32'd0);
    check_eq("cc_busy1", 32'(busy[1]), 32'd1);
    check_eq("cc_busy5", 32'(busy[5]), 32'd0);
    check_eq("cc_ip20", 32'(ip[20]), 32'd1);
    irq[1] = 1'b0;
    irq[20] = 1'b0;
    ticks(3);
    do_complete(1);
    do_claim(20);
    do_complete(20);

    // Edge source 2: rising edge lands in the claim cycle.
    edge_sel[2] = 1'b1;
    irq[2] = 1'b1;
    tick();
    irq[2] = 1'b0;
    ticks(2);
    check_eq("e2_pend", 32'(ip[2]), 32'd1);
    irq[2] = 1'b1;
    tick();
    irq[2] = 1'b0;
    tick();
    do_claim(2);
    check_eq("e2_busy", 32'(busy[2]), 32'd1);
    check_eq("e2_ip", 32'(ip[2]), 32'd0);
    do_complete(2);
    check_eq("e2_repend", 32'(ip[2]), 32'd1);
    do_claim(2);
    do_complete(2);
    check_eq("e2_idle", 32'(ip[2] | busy[2]), 32'd0);

    // Asynchronous reset with source 4 pending and 9 in service.
    irq[4] = 1'b1;
    irq[9] = 1'b1;
    ticks(3);
    do_claim(9);
    check_eq("rst_pre_ip4", 32'(ip[4]), 32'd1);
    check_eq("rst_pre_busy9", 32'(busy[9]), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_ip", 32'(ip), 32'd0);
    check_eq("rst_async_busy", 32'(busy), 32'd0);
    model_reset();
    irq[9] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_held_ip", 32'(ip), 32'd0);
    #2;
    rst_n = 1'b1;
    ticks(2);
    check_eq("rst_lat_ip4_early", 32'(ip[4]), 32'd0);
    tick();
    check_eq("rst_lat_ip4", 32'(ip[4]), 32'd1);
    check_eq("rst_busy9", 32'(busy[9]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
